// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the arbiter FSM state encoding and the channel-index width helper.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_WAIT  = 2'd1,
      WRITE_WAIT = 2'd2,
      RELEASE    = 2'd3
   } arb_state_t;

   // Bits needed to index one of num_consumers channels (at least 1).
   function automatic int index_bits(input int num_consumers);
      return (num_consumers > 1) ? $clog2(num_consumers) : 1;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_select.sv
// Round-robin selector: picks the first pending channel at or after rr_ptr,
// scanning upward and wrapping past the top channel. Purely combinational.
module rr_select #(
   parameter int NUM_CONSUMERS = 4,
   parameter int INDEX_BITS    = 2
) (
   input  logic [NUM_CONSUMERS-1:0] pending,
   input  logic [INDEX_BITS-1:0]    rr_ptr,
   output logic                     grant_valid,
   output logic [INDEX_BITS-1:0]    grant_index
);

   localparam logic [INDEX_BITS:0] NUM_WIDE = (INDEX_BITS+1)'(NUM_CONSUMERS);

   // rotated[k] is the pending bit of the channel k places after rr_ptr
   logic [NUM_CONSUMERS-1:0] rotated;
   logic [INDEX_BITS-1:0]    offset;
   logic [INDEX_BITS:0]      grant_sum;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_rotate
         logic [INDEX_BITS:0]   sum;
         logic [INDEX_BITS-1:0] src;
         assign sum = {1'b0, rr_ptr} + (INDEX_BITS+1)'(gi);
         assign src = (sum >= NUM_WIDE) ? INDEX_BITS'(sum - NUM_WIDE) : INDEX_BITS'(sum);
         assign rotated[gi] = pending[src];
      end
   endgenerate

   // Lowest set bit of the rotated vector is the distance from the pointer
   always_comb begin
      offset = '0;
      for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            offset = INDEX_BITS'(k);
         end
      end
   end

   assign grant_valid = |rotated;
   assign grant_sum   = {1'b0, rr_ptr} + {1'b0, offset};
   assign grant_index = (grant_sum >= NUM_WIDE) ? INDEX_BITS'(grant_sum - NUM_WIDE)
                                                : INDEX_BITS'(grant_sum);

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among LSU channels.
// One transaction at a time: grant, wait for memory, hand ready back to the
// winner, then wait for the winner to drop its valid before re-arbitrating.
// Build option: DATA_MEM_ARB_WRITE_EN enables write arbitration; without it
// the block is read-only and every write-side output is held at 0.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic                               mem_read_valid,
   output logic [ADDR_BITS-1:0]               mem_read_address,
   input  logic                               mem_read_ready,
   input  logic [DATA_BITS-1:0]               mem_read_data,
   output logic                               mem_write_valid,
   output logic [ADDR_BITS-1:0]               mem_write_address,
   output logic [DATA_BITS-1:0]               mem_write_data,
   input  logic                               mem_write_ready
);

   localparam int IB = index_bits(NUM_CONSUMERS);

   arb_state_t                     state_reg, state_next;
   logic [IB-1:0]                  winner_reg, winner_next;
   logic [IB-1:0]                  rr_ptr_reg, rr_ptr_next;
   logic [NUM_CONSUMERS-1:0]       read_ready_reg, read_ready_next;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_reg, read_data_next;
   logic [NUM_CONSUMERS-1:0]       write_ready_reg, write_ready_next;
   logic                           mem_rd_valid_reg, mem_rd_valid_next;
   logic [ADDR_BITS-1:0]           mem_rd_addr_reg, mem_rd_addr_next;
   logic                           mem_wr_valid_reg, mem_wr_valid_next;
   logic [ADDR_BITS-1:0]           mem_wr_addr_reg, mem_wr_addr_next;
   logic [DATA_BITS-1:0]           mem_wr_data_reg, mem_wr_data_next;

   // Write-side requests and completions as seen by the FSM
   logic [NUM_CONSUMERS-1:0] write_req;
   logic                     write_done;
   logic [NUM_CONSUMERS-1:0] pending;
   logic                     grant_valid;
   logic [IB-1:0]            grant_index;

`ifdef DATA_MEM_ARB_WRITE_EN
   assign write_req  = consumer_write_valid;
   assign write_done = mem_write_ready;
`else
   // Read-only build: write requests never become pending
   assign write_req  = '0;
   assign write_done = 1'b0;
   logic unused_write_inputs;
   assign unused_write_inputs = ^{consumer_write_valid, mem_write_ready};
`endif

   assign pending = consumer_read_valid | write_req;

   rr_select #(
      .NUM_CONSUMERS (NUM_CONSUMERS),
      .INDEX_BITS    (IB)
   ) u_rr_select (
      .pending     (pending),
      .rr_ptr      (rr_ptr_reg),
      .grant_valid (grant_valid),
      .grant_index (grant_index)
   );

   // State and registered outputs; reset abandons any in-flight request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg        <= IDLE;
         winner_reg       <= '0;
         rr_ptr_reg       <= '0;
         read_ready_reg   <= '0;
         read_data_reg    <= '0;
         write_ready_reg  <= '0;
         mem_rd_valid_reg <= 1'b0;
         mem_rd_addr_reg  <= '0;
         mem_wr_valid_reg <= 1'b0;
         mem_wr_addr_reg  <= '0;
         mem_wr_data_reg  <= '0;
      end else begin
         state_reg        <= state_next;
         winner_reg       <= winner_next;
         rr_ptr_reg       <= rr_ptr_next;
         read_ready_reg   <= read_ready_next;
         read_data_reg    <= read_data_next;
         write_ready_reg  <= write_ready_next;
         mem_rd_valid_reg <= mem_rd_valid_next;
         mem_rd_addr_reg  <= mem_rd_addr_next;
         mem_wr_valid_reg <= mem_wr_valid_next;
         mem_wr_addr_reg  <= mem_wr_addr_next;
         mem_wr_data_reg  <= mem_wr_data_next;
      end
   end

   // Next-state and next-output logic; everything holds unless changed below
   always_comb begin
      state_next        = state_reg;
      winner_next       = winner_reg;
      rr_ptr_next       = rr_ptr_reg;
      read_ready_next   = read_ready_reg;
      read_data_next    = read_data_reg;
      write_ready_next  = write_ready_reg;
      mem_rd_valid_next = mem_rd_valid_reg;
      mem_rd_addr_next  = mem_rd_addr_reg;
      mem_wr_valid_next = mem_wr_valid_reg;
      mem_wr_addr_next  = mem_wr_addr_reg;
      mem_wr_data_next  = mem_wr_data_reg;

      case (state_reg)
         IDLE: begin
            if (grant_valid) begin
               winner_next = grant_index;
               rr_ptr_next = (grant_index == IB'(NUM_CONSUMERS - 1)) ? '0 : grant_index + IB'(1);
               // A read beats a simultaneous write on the same channel
               if (consumer_read_valid[grant_index]) begin
                  mem_rd_valid_next = 1'b1;
                  mem_rd_addr_next  = consumer_read_address[grant_index*ADDR_BITS +: ADDR_BITS];
                  state_next        = READ_WAIT;
               end else begin
                  mem_wr_valid_next = 1'b1;
                  mem_wr_addr_next  = consumer_write_address[grant_index*ADDR_BITS +: ADDR_BITS];
                  mem_wr_data_next  = consumer_write_data[grant_index*DATA_BITS +: DATA_BITS];
                  state_next        = WRITE_WAIT;
               end
            end
         end
         READ_WAIT: begin
            if (mem_read_ready) begin
               mem_rd_valid_next = 1'b0;
               read_data_next[winner_reg*DATA_BITS +: DATA_BITS] = mem_read_data;
               read_ready_next[winner_reg] = 1'b1;
               state_next = RELEASE;
            end
         end
         WRITE_WAIT: begin
            if (write_done) begin
               mem_wr_valid_next = 1'b0;
               write_ready_next[winner_reg] = 1'b1;
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            // Wait for the winner to retire the request it was served for
            if (read_ready_reg[winner_reg]) begin
               if (!consumer_read_valid[winner_reg]) begin
                  read_ready_next[winner_reg] = 1'b0;
                  state_next = IDLE;
               end
            end else if (!write_req[winner_reg]) begin
               write_ready_next[winner_reg] = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

`ifndef DATA_MEM_ARB_WRITE_EN
      mem_wr_valid_next = 1'b0;
      mem_wr_addr_next  = '0;
      mem_wr_data_next  = '0;
      write_ready_next  = '0;
`endif
   end

   assign consumer_read_ready  = read_ready_reg;
   assign consumer_read_data   = read_data_reg;
   assign consumer_write_ready = write_ready_reg;
   assign mem_read_valid       = mem_rd_valid_reg;
   assign mem_read_address     = mem_rd_addr_reg;
   assign mem_write_valid      = mem_wr_valid_reg;
   assign mem_write_address    = mem_wr_addr_reg;
   assign mem_write_data       = mem_wr_data_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed requests push expected
// memory-side and consumer-side transactions; a monitor pops and compares.
module tb_data_mem_arbiter;

   localparam int AB = 8;
   localparam int DB = 8;
   localparam int NC = 4;
   localparam int BOUND = 300;

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic [NC-1:0] rv = '0;
   logic [NC-1:0] wv = '0;
   logic [AB-1:0] raddr [NC];
   logic [AB-1:0] waddr [NC];
   logic [DB-1:0] wdata [NC];
   logic [NC*AB-1:0] raddr_flat, waddr_flat;
   logic [NC*DB-1:0] wdata_flat;

   logic [NC-1:0]    consumer_read_ready, consumer_write_ready;
   logic [NC*DB-1:0] consumer_read_data;
   logic             mem_read_valid, mem_write_valid;
   logic [AB-1:0]    mem_read_address, mem_write_address;
   logic [DB-1:0]    mem_write_data;
   logic             mem_read_ready = 1'b0;
   logic             mem_write_ready = 1'b0;
   logic [DB-1:0]    mem_read_data = '0;

   genvar gi;
   generate
      for (gi = 0; gi < NC; gi++) begin : g_flat
         assign raddr_flat[gi*AB +: AB] = raddr[gi];
         assign waddr_flat[gi*AB +: AB] = waddr[gi];
         assign wdata_flat[gi*DB +: DB] = wdata[gi];
      end
   endgenerate

   data_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .consumer_read_valid    (rv),
      .consumer_read_address  (raddr_flat),
      .consumer_read_ready    (consumer_read_ready),
      .consumer_read_data     (consumer_read_data),
      .consumer_write_valid   (wv),
      .consumer_write_address (waddr_flat),
      .consumer_write_data    (wdata_flat),
      .consumer_write_ready   (consumer_write_ready),
      .mem_read_valid         (mem_read_valid),
      .mem_read_address       (mem_read_address),
      .mem_read_ready         (mem_read_ready),
      .mem_read_data          (mem_read_data),
      .mem_write_valid        (mem_write_valid),
      .mem_write_address      (mem_write_address),
      .mem_write_data         (mem_write_data),
      .mem_write_ready        (mem_write_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { bit rd; bit wr; logic [7:0] ra; logic [7:0] wa; logic [7:0] wd; } req_t;
   typedef struct { bit wr; logic [7:0] addr; logic [7:0] data; } mexp_t;
   typedef struct { int ch; bit wr; logic [7:0] data; } rexp_t;

   req_t  req_q [NC][$];
   mexp_t mem_q [$];
   rexp_t resp_q [$];

   int total = 0;
   int bad = 0;
   int txn = 0;

   logic [7:0] mem_model [256];
   int mem_lat = 1;
   int mem_ready_cyc = 0;
   int issue_cyc [NC];
   int drop_cyc [NC];
   bit abort [NC];
   int mem_req_cyc = 0, resp_cyc = 0, rfall_cyc = 0;
   int write_activity = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push_req(input int c, input bit rd, input bit wr, input logic [7:0] ra,
                           input logic [7:0] wa, input logic [7:0] wd);
      req_t r;
      r.rd = rd; r.wr = wr; r.ra = ra; r.wa = wa; r.wd = wd;
      req_q[c].push_back(r);
   endtask

   task automatic exp_mem(input bit wr, input logic [7:0] addr, input logic [7:0] data);
      mexp_t e;
      e.wr = wr; e.addr = addr; e.data = data;
      mem_q.push_back(e);
   endtask

   task automatic exp_resp(input int ch, input bit wr, input logic [7:0] data);
      rexp_t e;
      e.ch = ch; e.wr = wr; e.data = data;
      resp_q.push_back(e);
   endtask

   function automatic bit busy();
      for (int c = 0; c < NC; c++) if (req_q[c].size() != 0) return 1'b1;
      return |{rv, wv, consumer_read_ready, consumer_write_ready};
   endfunction

   task automatic wait_idle(input string name);
      int n = 0;
      while ((mem_q.size() != 0 || resp_q.size() != 0 || busy()) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check({name, "_timeout"}, 32'(n >= BOUND), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   // Memory model: answers a request mem_lat cycles after it first appears
   initial begin
      int rd_cnt = 0;
      int wr_cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (mem_read_ready) begin
            mem_read_ready = 1'b0; rd_cnt = 0;
         end else if (!mem_read_valid) begin
            rd_cnt = 0;
         end else begin
            rd_cnt++;
            if (rd_cnt > mem_lat) begin
               mem_read_ready = 1'b1;
               mem_read_data  = mem_model[mem_read_address];
               mem_ready_cyc  = cyc;
            end
         end
         if (mem_write_ready) begin
            mem_write_ready = 1'b0; wr_cnt = 0;
         end else if (!mem_write_valid) begin
            wr_cnt = 0;
         end else begin
            wr_cnt++;
            if (wr_cnt > mem_lat) begin
               mem_write_ready = 1'b1;
               mem_model[mem_write_address] = mem_write_data;
               mem_ready_cyc = cyc;
            end
         end
      end
   end

   // Consumer agents: retire on ready, then issue the next queued request
   initial begin
      req_t r;
      forever begin
         @(posedge clk); #1;
         for (int c = 0; c < NC; c++) begin
            if (abort[c]) begin
               rv[c] = 1'b0; wv[c] = 1'b0; abort[c] = 1'b0;
            end else begin
               if (rv[c] && consumer_read_ready[c]) begin rv[c] = 1'b0; drop_cyc[c] = cyc; end
               if (wv[c] && consumer_write_ready[c]) begin wv[c] = 1'b0; drop_cyc[c] = cyc; end
               if (!rv[c] && !wv[c] && !consumer_read_ready[c] && !consumer_write_ready[c]
                   && req_q[c].size() != 0) begin
                  r = req_q[c].pop_front();
                  rv[c] = r.rd; wv[c] = r.wr;
                  raddr[c] = r.ra; waddr[c] = r.wa; wdata[c] = r.wd;
                  issue_cyc[c] = cyc;
               end
            end
         end
      end
   end

   task automatic check_mem(input bit wr, input logic [7:0] addr, input logic [7:0] data);
      mexp_t e;
      mem_req_cyc = cyc;
      if (mem_q.size() == 0) begin
         total++; bad++;
         $display("FAIL mem_unexpected: got wr=%0d addr=%02h, expected no request", wr, addr);
      end else begin
         e = mem_q.pop_front();
         check("mem_kind", 32'(wr), 32'(e.wr));
         check("mem_addr", 32'(addr), 32'(e.addr));
         if (wr) check("mem_wdata", 32'(data), 32'(e.data));
      end
   endtask

   task automatic check_resp(input int c, input bit wr, input logic [7:0] data);
      rexp_t e;
      resp_cyc = cyc;
      txn++;
      $display("txn %0d: cycle %0d ch%0d %s data=%02h", txn, cyc, c, wr ? "write" : "read", data);
      if (resp_q.size() == 0) begin
         total++; bad++;
         $display("FAIL resp_unexpected: got ch%0d wr=%0d, expected no response", c, wr);
      end else begin
         e = resp_q.pop_front();
         check("resp_ch", 32'(c), 32'(e.ch));
         check("resp_kind", 32'(wr), 32'(e.wr));
         if (!wr) check("resp_data", 32'(data), 32'(e.data));
      end
   endtask

   // Monitor: compares DUT transactions against the scoreboard queues
   initial begin
      logic [NC-1:0] prev_rr = '0;
      logic [NC-1:0] prev_wr = '0;
      logic prev_mrv = 1'b0;
      logic prev_mwv = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (mem_read_valid && !prev_mrv) check_mem(1'b0, mem_read_address, '0);
         if (mem_write_valid && !prev_mwv) check_mem(1'b1, mem_write_address, mem_write_data);
         if (mem_write_valid || (|consumer_write_ready)) write_activity++;
         for (int c = 0; c < NC; c++) begin
            if (consumer_read_ready[c] && !prev_rr[c])
               check_resp(c, 1'b0, consumer_read_data[c*DB +: DB]);
            if (consumer_write_ready[c] && !prev_wr[c]) check_resp(c, 1'b1, '0);
            if (!consumer_read_ready[c] && prev_rr[c]) rfall_cyc = cyc;
         end
         prev_rr = consumer_read_ready; prev_wr = consumer_write_ready;
         prev_mrv = mem_read_valid; prev_mwv = mem_write_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem_model[i] = 8'(i ^ 8'hFF);
      for (int c = 0; c < NC; c++) begin
         raddr[c] = '0; waddr[c] = '0; wdata[c] = '0;
         issue_cyc[c] = 0; drop_cyc[c] = 0; abort[c] = 1'b0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #3;
      check("reset_outputs", 32'(|{consumer_read_ready, consumer_read_data, consumer_write_ready,
                                   mem_read_valid, mem_read_address, mem_write_valid,
                                   mem_write_address, mem_write_data}), 32'd0);
      @(negedge clk) reset = 1'b1;
      repeat (2) @(negedge clk);

      // Round robin: all four read together, ch0 re-requests -> 0,1,2,3,0
      mem_lat = 1;
      for (int c = 0; c < NC; c++) begin
         mem_model[8'h40 + c] = 8'hC0 + 8'(c);
         push_req(c, 1'b1, 1'b0, 8'h40 + 8'(c), 8'h00, 8'h00);
      end
      mem_model[8'h44] = 8'hD4;
      push_req(0, 1'b1, 1'b0, 8'h44, 8'h00, 8'h00);
      for (int c = 0; c < NC; c++) begin
         exp_mem(1'b0, 8'h40 + 8'(c), 8'h00);
         exp_resp(c, 1'b0, 8'hC0 + 8'(c));
      end
      exp_mem(1'b0, 8'h44, 8'h00);
      exp_resp(0, 1'b0, 8'hD4);
      wait_idle("rr");

      // Single read on ch1 with a 2-cycle memory latency
      mem_lat = 2;
      mem_model[8'h12] = 8'hA5;
      push_req(1, 1'b1, 1'b0, 8'h12, 8'h00, 8'h00);
      exp_mem(1'b0, 8'h12, 8'h00);
      exp_resp(1, 1'b0, 8'hA5);
      wait_idle("single");
      check("t_mem_request", 32'(mem_req_cyc - issue_cyc[1]), 32'd1);
      check("t_read_ready", 32'(resp_cyc - issue_cyc[1]), 32'd4);
      check("t_ready_release", 32'(rfall_cyc - drop_cyc[1]), 32'd1);

`ifdef DATA_MEM_ARB_WRITE_EN
      // ch2 read+write together with ch0, ch3 reads; pointer sits at 2
      mem_lat = 1;
      mem_model[8'h05] = 8'h11; mem_model[8'h53] = 8'h63; mem_model[8'h54] = 8'h64;
      push_req(2, 1'b1, 1'b1, 8'h05, 8'h06, 8'h3C);
      push_req(0, 1'b1, 1'b0, 8'h53, 8'h00, 8'h00);
      push_req(3, 1'b1, 1'b0, 8'h54, 8'h00, 8'h00);
      exp_mem(1'b0, 8'h05, 8'h00); exp_resp(2, 1'b0, 8'h11);
      exp_mem(1'b0, 8'h54, 8'h00); exp_resp(3, 1'b0, 8'h64);
      exp_mem(1'b0, 8'h53, 8'h00); exp_resp(0, 1'b0, 8'h63);
      exp_mem(1'b1, 8'h06, 8'h3C); exp_resp(2, 1'b1, 8'h00);
      wait_idle("priority");
      check("prio_mem_written", 32'(mem_model[8'h06]), 32'h3C);

      // Write on ch3
      push_req(3, 1'b0, 1'b1, 8'h00, 8'h20, 8'h7F);
      exp_mem(1'b1, 8'h20, 8'h7F);
      exp_resp(3, 1'b1, 8'h00);
      wait_idle("write");
      check("t_write_ready", 32'(resp_cyc - mem_ready_cyc), 32'd1);
      check("write_mem_written", 32'(mem_model[8'h20]), 32'h7F);
`else
      // Read-only build: ch0 write is ignored, ch1 read completes
      mem_lat = 1;
      mem_model[8'h30] = 8'h5A;
      push_req(0, 1'b0, 1'b1, 8'h00, 8'h10, 8'h99);
      push_req(1, 1'b1, 1'b0, 8'h30, 8'h00, 8'h00);
      exp_mem(1'b0, 8'h30, 8'h00);
      exp_resp(1, 1'b0, 8'h5A);
      n = 0;
      while ((mem_q.size() != 0 || resp_q.size() != 0) && n < BOUND) begin
         @(negedge clk); n++;
      end
      check("ro_timeout", 32'(n >= BOUND), 32'd0);
      repeat (10) @(negedge clk);
      check("ro_write_activity", 32'(write_activity), 32'd0);
      check("ro_write_pending", 32'(wv[0]), 32'd1);
      abort[0] = 1'b1;
      wait_idle("ro");
`endif

      // Reset during READ_WAIT; afterwards ch0 must beat ch3 (pointer back to 0)
      mem_lat = 6;
      mem_model[8'h50] = 8'h70;
      push_req(2, 1'b1, 1'b0, 8'h50, 8'h00, 8'h00);
      exp_mem(1'b0, 8'h50, 8'h00);
      n = 0;
      while (!mem_read_valid && n < 50) begin
         @(negedge clk); n++;
      end
      check("rst_wait_timeout", 32'(n >= 50), 32'd0);
      @(negedge clk) reset = 1'b0;
      #1;
      check("rst_async_outputs", 32'(|{consumer_read_ready, consumer_read_data, consumer_write_ready,
                                       mem_read_valid, mem_read_address, mem_write_valid,
                                       mem_write_address, mem_write_data}), 32'd0);
      abort[2] = 1'b1;
      mem_model[8'h51] = 8'h61; mem_model[8'h52] = 8'h62;
      push_req(0, 1'b1, 1'b0, 8'h51, 8'h00, 8'h00);
      push_req(3, 1'b1, 1'b0, 8'h52, 8'h00, 8'h00);
      exp_mem(1'b0, 8'h51, 8'h00); exp_resp(0, 1'b0, 8'h61);
      exp_mem(1'b0, 8'h52, 8'h00); exp_resp(3, 1'b0, 8'h62);
      repeat (2) @(negedge clk);
      mem_lat = 1;
      reset = 1'b1;
      wait_idle("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Round-robin arbiter that shares one data-memory port among the per-thread LSU channels of a compute core. Each LSU channel presents a valid/ready read or write request. The arbiter grants one request at a time, drives the shared memory port, and returns read data and the ready handshake to the winning channel. It sits between the core's per-thread LSU request arrays and the device data-memory interface.

## Interface
- ADDR_BITS, 8, data-memory address width
- DATA_BITS, 8, data-memory word width
- NUM_CONSUMERS, 4, number of LSU channels (≥2)
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- consumer_read_valid  input  NUM_CONSUMERS  per-channel read request
- consumer_read_address  input  NUM_CONSUMERS×ADDR_BITS  read address, held while valid
- consumer_read_ready  output  NUM_CONSUMERS  read complete; data valid
- consumer_read_data  output  NUM_CONSUMERS×DATA_BITS  registered read data
- consumer_write_valid  input  NUM_CONSUMERS  per-channel write request
- consumer_write_address  input  NUM_CONSUMERS×ADDR_BITS  write address
- consumer_write_data  input  NUM_CONSUMERS×DATA_BITS  write data
- consumer_write_ready  output  NUM_CONSUMERS  write complete
- mem_read_valid  output  1  memory read request
- mem_read_address  output  ADDR_BITS
- mem_read_ready  input  1  memory read done; mem_read_data valid this cycle
- mem_read_data  input  DATA_BITS
- mem_write_valid  output  1  memory write request
- mem_write_address  output  ADDR_BITS
- mem_write_data  output  DATA_BITS
- mem_write_ready  input  1  memory write done

## Operation
- All outputs are registered. Reset value of every output and of every data/address output is 0. rr_ptr resets to 0 and state to IDLE.
- States: IDLE, READ_WAIT, WRITE_WAIT, RELEASE.
- IDLE: a channel is pending if read_valid or write_valid is high. Grant goes to the first pending channel at or after rr_ptr, in ascending order with wrap-around.
  - Register the winner index.
  - If the winner's read_valid is high, launch a read (read wins over a simultaneous write on the same channel) → READ_WAIT. Otherwise launch a write → WRITE_WAIT.
  - Set rr_ptr = winner+1 mod NUM_CONSUMERS.
  - No pending channel: stay in IDLE, outputs unchanged.
- READ_WAIT: hold mem_read_valid/address. On mem_read_ready: capture mem_read_data into consumer_read_data[winner], drop mem_read_valid, set consumer_read_ready[winner] → RELEASE.
- WRITE_WAIT: symmetric. On mem_write_ready: drop mem_write_valid, set consumer_write_ready[winner] → RELEASE.
- RELEASE: hold the ready bit until the winner drops the corresponding valid. Then clear the ready bit → IDLE.
- consumer_read_data[i] holds its value until the next read granted to channel i.
- Address/data are sampled only at grant. Changes to them while a request is waiting are ignored.
- Reset asserted mid-transaction: everything clears immediately, including an in-flight memory request. The memory side must tolerate an abandoned request.

## Timing
- Request at cycle 0 with the arbiter in IDLE → mem_*_valid high at cycle 1.
- mem_*_ready at cycle k → consumer_*_ready high at k+1.
- Consumer drops valid at cycle m → ready low and IDLE at m+1. The earliest next grant is at m+1, with its memory request at m+2.
- Minimum 4 cycles per transaction with a zero-wait memory (ready in the cycle after valid).
- Fairness: a pending channel waits at most NUM_CONSUMERS−1 transactions.

## Configuration
- DATA_MEM_ARB_WRITE_EN defined: full read/write arbitration as above.
- DATA_MEM_ARB_WRITE_EN not defined (read-only variant, e.g. for program memory):
  - consumer_write_valid is ignored and does not count as pending.
  - consumer_write_ready, mem_write_valid, mem_write_address and mem_write_data are tied to 0.
  - WRITE_WAIT is unreachable.
- The port list is identical in both builds.

## Structure
- Package data_mem_arb_pkg contains:
  - the state enum typedef (IDLE, READ_WAIT, WRITE_WAIT, RELEASE)
  - the function computing index width as $clog2(NUM_CONSUMERS)
- Sub-module rr_select: combinational. Inputs: pending vector and rr_ptr. Outputs: grant_valid and grant_index (first set bit at or after the pointer, wrapping).

## Test plan
- Single read: ch1 reads addr 0x12, memory returns 0xA5 with 2-cycle latency → mem_read_address=0x12 at cycle 1; consumer_read_ready[1] high at cycle 4 with data 0xA5; drops the cycle after ch1 deasserts valid.
- Round-robin: all 4 channels request reads at once and re-request immediately → grant order 0,1,2,3,0. No channel is served twice before the others are served.
- Read/write priority on one channel: ch2 asserts read 0x05 and write 0x06←0x3C together → read served first. The write is granted only after every other pending channel has been served in rr order.
- Write: ch3 writes 0x7F to addr 0x20 → mem_write_valid/address/data = 1/0x20/0x7F. consumer_write_ready[3] follows mem_write_ready by one cycle.
- Reset mid-operation: reset asserted in READ_WAIT → all outputs 0 asynchronously, rr_ptr=0. After release, a ch0 request is granted normally.
- Build with DATA_MEM_ARB_WRITE_EN undefined: a write request on ch0 → mem_write_valid stays 0 and consumer_write_ready stays 0. A concurrent read on ch1 completes normally.
